riscv64g_iss_trap_seq: RTL

RISCV64G_ISS_TRAP_SEQ -- requirements
Module: RISCV64G_ISS_TRAP_SEQ

---
 rtl/riscv64g_iss_pkg.sv | 39 +++
 rtl/riscv64g_iss_trap_seq.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/riscv64g_iss_pkg.sv
// Shared definitions for the RV64G ISS trap sequencer.
// Holds the machine-mode CSR addresses used by the trap/return flow,
// the sequencer state enum and the trap-vector target helper.
package riscv64g_iss_pkg;

    localparam logic [11:0] CSR_MEPC   = 12'h341;
    localparam logic [11:0] CSR_MCAUSE = 12'h342;
    localparam logic [11:0] CSR_MTVAL  = 12'h343;
    localparam logic [11:0] CSR_MTVEC  = 12'h305;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        W_EPC    = 3'd1,
        W_CAUSE  = 3'd2,
        W_TVAL   = 3'd3,
        R_TVEC   = 3'd4,
        R_EPC    = 3'd5,
        REDIRECT = 3'd6
    } trap_state_e;

    // Trap target from mtvec: base with mode bits cleared, plus 4*code when
    // mtvec is in vectored mode and the cause is an interrupt. Operates on
    // 64-bit values; callers zero-extend and truncate to their XLEN, which
    // gives the required modulo-XLEN result.
    function automatic logic [63:0] vector_target(
        input logic [63:0] tvec,
        input logic        intr,
        input logic [63:0] code
    );
        logic [63:0] base;
        base = {tvec[63:2], 2'b00};
        if ((tvec[1:0] == 2'b01) && intr) begin
            vector_target = base + {code[61:0], 2'b00};
        end else begin
            vector_target = base;
        end
    endfunction

endpackage

// File: rtl/riscv64g_iss_trap_seq.sv
// Trap entry / MRET sequencer for the RV64G ISS.
// On a trap it writes mepc, mcause (and mtval when RISCV64G_ISS_TRAP_TVAL_EN
// is defined), reads mtvec and issues a one-cycle redirect to the handler.
// On MRET it reads mepc and redirects there. While idle the instruction-side
// CSR port passes straight through to the CSR file.
// Ports:
//   CLK, RSTn                         clock, synchronous active-low reset
//   req_valid/we/a/wd, req_ready/rd   instruction-side CSR access
//   trap_valid/pc/cause/tval, trap_ready   trap request
//   mret_valid                        return-from-trap request
//   csr_we/a/wd, csr_rd               CSR file port (csr_rd combinational)
//   redirect_valid, redirect_pc       fetch redirect (registered)
// Configuration macro: RISCV64G_ISS_TRAP_TVAL_EN (adds the mtval write).
module riscv64g_iss_trap_seq
    import riscv64g_iss_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            CLK,
    input  logic            RSTn,
    input  logic            req_valid,
    input  logic            req_we,
    input  logic [11:0]     req_a,
    input  logic [XLEN-1:0] req_wd,
    output logic            req_ready,
    output logic [XLEN-1:0] req_rd,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_pc,
    input  logic [XLEN-1:0] trap_cause,
    input  logic [XLEN-1:0] trap_tval,
    output logic            trap_ready,
    input  logic            mret_valid,
    output logic            csr_we,
    output logic [11:0]     csr_a,
    output logic [XLEN-1:0] csr_wd,
    input  logic [XLEN-1:0] csr_rd,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc
);

    trap_state_e     state_r;
    logic [XLEN-1:0] pc_r;
    logic [XLEN-1:0] cause_r;
    logic [XLEN-1:0] target_r;
    logic            redirect_valid_r;
    logic [XLEN-1:0] redirect_pc_r;
    logic            idle_free_s;
    logic [XLEN-1:0] code_s;
`ifdef RISCV64G_ISS_TRAP_TVAL_EN
    logic [XLEN-1:0] tval_r;
`else
    logic            unused_tval_s;
    assign unused_tval_s = ^trap_tval;
`endif

    // Idle with no competing trap/MRET: instruction side owns the CSR port.
    assign idle_free_s = (state_r == IDLE) && !trap_valid && !mret_valid && RSTn;
    assign code_s      = {1'b0, cause_r[XLEN-2:0]};

    assign redirect_valid = redirect_valid_r;
    assign redirect_pc    = redirect_pc_r;

    // CSR port steering and handshakes, decoded from the current state.
    // Writes are suppressed while RSTn is low so an abandoned sequence
    // never lands a write on the reset edge.
    always_comb begin
        csr_we     = 1'b0;
        csr_a      = 12'h000;
        csr_wd     = '0;
        req_ready  = 1'b0;
        req_rd     = '0;
        trap_ready = 1'b0;
        case (state_r)
            IDLE: begin
                trap_ready = !trap_valid && !mret_valid;
                if (idle_free_s) begin
                    req_ready = 1'b1;
                    csr_we    = req_valid & req_we;
                    csr_a     = req_a;
                    csr_wd    = req_wd;
                    req_rd    = csr_rd;
                end else begin
                    req_ready = 1'b0;
                end
            end
            W_EPC: begin
                csr_we = RSTn;
                csr_a  = CSR_MEPC;
                csr_wd = pc_r;
            end
            W_CAUSE: begin
                csr_we = RSTn;
                csr_a  = CSR_MCAUSE;
                csr_wd = cause_r;
            end
`ifdef RISCV64G_ISS_TRAP_TVAL_EN
            W_TVAL: begin
                csr_we = RSTn;
                csr_a  = CSR_MTVAL;
                csr_wd = tval_r;
            end
`endif
            R_TVEC: begin
                csr_a = CSR_MTVEC;
            end
            R_EPC: begin
                csr_a = CSR_MEPC;
            end
            default: begin
                csr_we = 1'b0;
            end
        endcase
    end

    // Sequencer state, trap latches, target and registered redirect.
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state_r          <= IDLE;
            pc_r             <= '0;
            cause_r          <= '0;
            target_r         <= '0;
            redirect_valid_r <= 1'b0;
            redirect_pc_r    <= '0;
`ifdef RISCV64G_ISS_TRAP_TVAL_EN
            tval_r           <= '0;
`endif
        end else begin
            redirect_valid_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    // Trap has priority; a simultaneous MRET is dropped.
                    if (trap_valid) begin
                        pc_r    <= {trap_pc[XLEN-1:1], 1'b0};
                        cause_r <= trap_cause;
`ifdef RISCV64G_ISS_TRAP_TVAL_EN
                        tval_r  <= trap_tval;
`endif
                        state_r <= W_EPC;
                    end else if (mret_valid) begin
                        state_r <= R_EPC;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                W_EPC: state_r <= W_CAUSE;
`ifdef RISCV64G_ISS_TRAP_TVAL_EN
                W_CAUSE: state_r <= W_TVAL;
                W_TVAL:  state_r <= R_TVEC;
`else
                W_CAUSE: state_r <= R_TVEC;
`endif
                R_TVEC: begin
                    target_r <= XLEN'(vector_target(64'(csr_rd), cause_r[XLEN-1], 64'(code_s)));
                    state_r  <= REDIRECT;
                end
                R_EPC: begin
                    target_r <= {csr_rd[XLEN-1:1], 1'b0};
                    state_r  <= REDIRECT;
                end
                REDIRECT: begin
                    redirect_valid_r <= 1'b1;
                    redirect_pc_r    <= target_r;
                    state_r          <= IDLE;
                end
                default: state_r <= IDLE;
            endcase
        end
    end

endmodule
